// File: rtl/vlg_pkt_pkg.sv
// Shared definitions for the packet source: state encoding and default parameter values.
package vlg_pkt_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PKT_LEN = 16;
    localparam int DEF_GAP_CYC = 4;
    localparam int DEF_PKT_NUM = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/vlg_pkt_src.sv
// Packet generator: emits PKT_LEN-beat packets with beat data (packet + beat index),
// separated by GAP_CYC idle cycles, optionally stopping after PKT_NUM packets.
module vlg_pkt_src
    import vlg_pkt_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int PKT_NUM = DEF_PKT_NUM
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic [15:0]       o_pkt_cnt,
    output logic              o_done,
    output logic [1:0]        o_state
);

    localparam logic [7:0]  LAST_BEAT = 8'(PKT_LEN - 1);
    localparam logic [7:0]  LAST_GAP  = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [15:0] PKT_TGT   = 16'(PKT_NUM);
    localparam bit          HAS_LIMIT = (PKT_NUM != 0);
    localparam bit          HAS_GAP   = (GAP_CYC > 0);

    state_t            state, state_nxt;
    logic [7:0]        beat_cnt, beat_cnt_nxt;
    logic [7:0]        gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] pkt_base, pkt_base_nxt;
    logic [15:0]       pkt_cnt_nxt;
    logic              xfer;
    logic              last_beat;

    // Handshake: a beat moves on a rising edge where o_valid and i_ready are both high;
    // while o_valid is high and i_ready low, the counters freeze so data/sop/eop hold.
    assign xfer      = (state == SEND) && i_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pkt_base  <= '0;
            o_pkt_cnt <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            pkt_base  <= pkt_base_nxt;
            o_pkt_cnt <= pkt_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        gap_cnt_nxt  = gap_cnt;
        pkt_base_nxt = pkt_base;
        pkt_cnt_nxt  = o_pkt_cnt;
        case (state)
            IDLE: begin
                if (i_en) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!last_beat) begin
                        beat_cnt_nxt = beat_cnt + 8'd1;
                    end else begin
                        // Packet finished: i_en is only looked at here, so packets never truncate.
                        beat_cnt_nxt = '0;
                        gap_cnt_nxt  = '0;
                        pkt_base_nxt = pkt_base + DATA_W'(1);
                        pkt_cnt_nxt  = o_pkt_cnt + 16'd1;
                        if (HAS_LIMIT && (pkt_cnt_nxt == PKT_TGT)) begin
                            state_nxt = DONE;
                        end else if (HAS_GAP) begin
                            state_nxt = GAP;
                        end else if (!i_en) begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = i_en ? SEND : IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_valid = (state == SEND);
    assign o_data  = o_valid ? (pkt_base + DATA_W'(beat_cnt)) : '0;
    assign o_sop   = o_valid && (beat_cnt == 8'd0);
    assign o_eop   = o_valid && last_beat;
    assign o_done  = (state == DONE);
    assign o_state = state;

endmodule

// File: tb/tb_vlg_pkt_src.sv
// Bench for vlg_pkt_src: four instances with different packet shapes, a beat scoreboard
// per instance and directed timing checks around gaps, stalls, limits and reset.
module tb_vlg_pkt_src;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [N];
    logic        en     [N];
    logic        ready  [N];
    logic        valid  [N];
    logic        sop    [N];
    logic        eop    [N];
    logic        done   [N];
    logic [7:0]  data   [N];
    logic [15:0] pkt_cnt[N];
    logic [1:0]  state  [N];

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [9:0] exp_q2[$];
    logic [9:0] exp_q3[$];

    vlg_pkt_src #(.DATA_W(8), .PKT_LEN(4), .GAP_CYC(2), .PKT_NUM(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_en(en[0]), .i_ready(ready[0]),
        .o_valid(valid[0]), .o_data(data[0]), .o_sop(sop[0]), .o_eop(eop[0]),
        .o_pkt_cnt(pkt_cnt[0]), .o_done(done[0]), .o_state(state[0]));

    vlg_pkt_src #(.DATA_W(8), .PKT_LEN(2), .GAP_CYC(1), .PKT_NUM(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_en(en[1]), .i_ready(ready[1]),
        .o_valid(valid[1]), .o_data(data[1]), .o_sop(sop[1]), .o_eop(eop[1]),
        .o_pkt_cnt(pkt_cnt[1]), .o_done(done[1]), .o_state(state[1]));

    vlg_pkt_src #(.DATA_W(8), .PKT_LEN(1), .GAP_CYC(0), .PKT_NUM(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_en(en[2]), .i_ready(ready[2]),
        .o_valid(valid[2]), .o_data(data[2]), .o_sop(sop[2]), .o_eop(eop[2]),
        .o_pkt_cnt(pkt_cnt[2]), .o_done(done[2]), .o_state(state[2]));

    vlg_pkt_src #(.DATA_W(8), .PKT_LEN(8), .GAP_CYC(0), .PKT_NUM(0)) u3 (
        .i_clk(clk), .i_rst_n(rst_n[3]), .i_en(en[3]), .i_ready(ready[3]),
        .o_valid(valid[3]), .o_data(data[3]), .o_sop(sop[3]), .o_eop(eop[3]),
        .o_pkt_cnt(pkt_cnt[3]), .o_done(done[3]), .o_state(state[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int d, input bit s, input bit e);
        logic [9:0] v;
        v = {s, e, 8'(d)};
        case (id)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            2: exp_q2.push_back(v);
            default: exp_q3.push_back(v);
        endcase
    endtask

    function automatic bit pop_exp(input int id, output logic [9:0] v);
        v = '0;
        case (id)
            0: if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); return 1'b1; end
            1: if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); return 1'b1; end
            2: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); return 1'b1; end
            default: if (exp_q3.size() > 0) begin v = exp_q3.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int q_size(input int id);
        case (id)
            0: return exp_q0.size();
            1: return exp_q1.size();
            2: return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    // Monitor: pops one expected beat per transfer and checks that stalled beats hold.
    logic        stall_prev[N] = '{default: 1'b0};
    logic [10:0] stall_beat[N] = '{default: 11'd0};

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [10:0] got;
            logic [9:0]  want;
            got = {valid[i], sop[i], eop[i], data[i]};
            if (stall_prev[i] && rst_n[i])
                check($sformatf("hold_u%0d", i), 32'(got), 32'(stall_beat[i]));
            stall_prev[i] = valid[i] && !ready[i] && rst_n[i];
            stall_beat[i] = got;
            if (valid[i] && ready[i]) begin
                if (pop_exp(i, want)) begin
                    check($sformatf("beat_u%0d", i), 32'(got[9:0]), 32'(want));
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_beat_u%0d: got %0h expected no beat", i, got[9:0]);
                end
            end
        end
    end

    initial begin
        logic [12:0] pat;
        bit          bad;

        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            en[i]    = 1'b0;
            ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("reset_u%0d", i),
                  {valid[i], sop[i], eop[i], done[i], state[i], data[i], pkt_cnt[i]}, 32'd0);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_en_u0", {31'd0, valid[0]}, 32'd0);

        // u0: two packets back to back with a 2-cycle gap, including first-beat latency.
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++) push(0, p + k, k == 0, k == 3);
        @(posedge clk);
        #1 en[0] = 1'b1;
        pat = '0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            pat = {pat[11:0], valid[0]};
        end
        en[0] = 1'b0;
        check("gap_pattern_u0", 32'(pat), 32'(13'b0111100111100));
        repeat (3) @(negedge clk);
        check("idle_after_gap_u0", {valid[0], 13'd0, state[0], pkt_cnt[0]}, {16'd0, 16'd2});

        // u0: stall on the first beat of packet 2, i_en dropped mid-packet.
        for (int k = 0; k < 4; k++) push(0, 2 + k, k == 0, k == 3);
        ready[0] = 1'b0;
        en[0]    = 1'b1;
        @(negedge clk);
        check("stall1_data_u0", {valid[0], sop[0], data[0], pkt_cnt[0]}, {1'b1, 1'b1, 8'd2, 16'd2});
        @(negedge clk);
        check("stall2_data_u0", {valid[0], sop[0], data[0], pkt_cnt[0]}, {1'b1, 1'b1, 8'd2, 16'd2});
        ready[0] = 1'b1;
        en[0]    = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_eop_cnt_u0", {eop[0], 7'd0, data[0], pkt_cnt[0]}, {1'b1, 7'd0, 8'd5, 16'd2});
        @(negedge clk);
        check("post_eop_cnt_u0", {16'd0, pkt_cnt[0]}, 32'd3);
        repeat (4) @(negedge clk);
        check("idle_after_drop_u0", {valid[0], state[0]}, 32'd0);

        // u1: limit of three packets, then sticky done with i_en held high.
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 2; k++) push(1, p + k, k == 0, k == 1);
        en[1] = 1'b1;
        repeat (14) @(negedge clk);
        check("done_u1", {done[1], state[1], pkt_cnt[1]}, {1'b1, 2'd3, 16'd3});
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid[1] || !done[1] || pkt_cnt[1] != 16'd3) bad = 1'b1;
        end
        check("done_sticky_u1", {31'd0, bad}, 32'd0);

        // u2: single-beat packets with no gap, across the 8-bit data wrap.
        for (int p = 0; p < 258; p++) push(2, p, 1'b1, 1'b1);
        @(posedge clk);
        #1 en[2] = 1'b1;
        repeat (258) @(posedge clk);
        #1 en[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("wrap_cnt_u2", {14'd0, state[2], pkt_cnt[2]}, 32'd258);

        // u3: i_en dropped at beat 1 of an 8-beat packet; packet still completes.
        for (int k = 0; k < 8; k++) push(3, k, k == 0, k == 7);
        @(posedge clk);
        #1 en[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 en[3] = 1'b0;
        repeat (12) @(negedge clk);
        check("en_drop_u3", {valid[3], 13'd0, state[3], pkt_cnt[3]}, 32'd1);

        // u3: reset while beat 5 of packet 1 is on the bus.
        for (int k = 0; k < 5; k++) push(3, 1 + k, k == 0, 1'b0);
        @(posedge clk);
        #1 en[3] = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst_n[3] = 1'b0;
        #1;
        check("async_rst_u3",
              {valid[3], sop[3], eop[3], done[3], state[3], data[3], pkt_cnt[3]}, 32'd0);
        en[3] = 1'b0;
        @(negedge clk);
        rst_n[3] = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle_u3", {valid[3], state[3]}, 32'd0);
        for (int k = 0; k < 8; k++) push(3, k, k == 0, k == 7);
        @(posedge clk);
        #1 en[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 en[3] = 1'b0;
        repeat (12) @(negedge clk);
        check("restart_u3", {valid[3], 13'd0, state[3], pkt_cnt[3]}, 32'd1);

        for (int i = 0; i < N; i++)
            check($sformatf("leftover_u%0d", i), 32'(q_size(i)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
